sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the IF inst requester and the EX/MEM data requester.
//  Fixed priority with grant lock until address acceptance. Tracks outstanding transactions in order, so each data_ok/rdata goes back to its issuer.
//  Sits between the pipeline stages (IF, EX/MEM) and the memory side (AXI bridge or SRAM wrapper).
// PARAMETERS
//  MAX_OUTSTANDING  2   max accepted-but-not-returned transactions (depth of source-ID FIFO, >=1)
// PORTS
//  clk                       in   1   clock, all state updates on posedge
//  resetn                    in   1   synchronous, active-low reset
//  inst_req / data_req       in   1   requester asserts request; held until its addr_ok
//  inst_wr / data_wr         in   1   1=write, 0=read
//  inst_size / data_size     in   2   0=byte,1=half,2=word
//  inst_wstrb / data_wstrb   in   4   byte write strobes
//  inst_addr / data_addr     in   32  byte address
//  inst_wdata / data_wdata   in   32  write data
//  inst_addr_ok/data_addr_ok out  1   request accepted this cycle
//  inst_data_ok/data_data_ok out  1   response for oldest outstanding of this source
//  inst_rdata / data_rdata   out  32  read data, valid with *_data_ok
//  mem_req,mem_wr,mem_size,mem_wstrb,mem_addr,mem_wdata  out  1,1,2,4,32,32  muxed request to memory
//  mem_addr_ok               in   1   memory accepted mem_req
//  mem_data_ok               in   1   memory returns response (in order)
//  mem_rdata                 in   32  memory read data
//  err_unexpected            out  1   sticky: mem_data_ok seen with no outstanding transaction
// BEHAVIOUR
//  - Arbitration (comb): if lock_vld, winner=lock_id; else data_req wins over inst_req; else inst.
//  - Grant blocked when outstanding count == MAX_OUTSTANDING (registered count, no same-cycle pop bypass).
//  - Grant blocked while resetn==0. Blocked: mem_req=0, both *_addr_ok=0.
//  - mem_req = winner's req & !blocked. mem_* fields are muxed from winner; unblocked-idle fields = data side.
//  - winner_addr_ok = mem_addr_ok & mem_req; loser_addr_ok = 0. Zero-cycle combinational path, no added latency.
//  - Lock: if mem_req & !mem_addr_ok, set lock_vld=1, lock_id=winner at posedge.
//    Cleared on the cycle mem_addr_ok=1. Locked winner keeps priority even if the other side requests.
//  - Lock survives full-blocking: it is held, and the request re-issues when a slot frees.
//  - Push: on mem_req & mem_addr_ok, push source ID (`SRC_INST / `SRC_DATA) into ID FIFO.
//  - Pop: on mem_data_ok & !empty, pop head. head==INST -> inst_data_ok=1, else data_data_ok=1. Same cycle, comb.
//  - inst_rdata = data_rdata = mem_rdata (broadcast). Only the data_ok strobe is routed.
//  - Simultaneous push+pop: both happen; count unchanged; pointers both advance; at full, push impossible (blocked).
//  - Empty & mem_data_ok: no pop, both data_ok=0, err_unexpected<=1 (held until reset).
//  - Pointers wrap modulo MAX_OUTSTANDING. count width = $clog2(MAX_OUTSTANDING+1).
//  - Reset (resetn=0 at posedge): rd/wr ptr=0, count=0, lock_vld=0, lock_id=0, err_unexpected=0.
//    While resetn=0, mem_req, *_addr_ok, *_data_ok are all 0. Mid-transaction reset drops all outstanding IDs; memory side must be reset together.
// STRUCTURE
//  - macro.vh: `SRC_INST 1'b0, `SRC_DATA 1'b1, `MEM_SIZE_B/H/W.
//  - One sub-module: src_id_fifo (sync FIFO, width 1, depth MAX_OUTSTANDING; push/pop/full/empty/head).
//  - Arbitration, lock and muxing stay in this module.
// TESTING
//  1 Reset: resetn=0 two cycles with inst_req=data_req=1, mem_addr_ok=1 -> mem_req=0, all ok=0, err_unexpected=0.
//  2 Contention: both req, data_addr=0x1000, inst_addr=0x1c000000, mem_addr_ok=1 -> mem_addr=0x1000, data_addr_ok=1, inst_addr_ok=0.
//    Next cycle, inst only -> mem_addr=0x1c000000.
//  3 Lock: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> mem_addr stays inst's until addr_ok.
//    Then data granted.
//  4 Ordering: issue inst,data,(full: third blocked, mem_req=0); mem_data_ok with rdata 0xAAAA, then 0x5555.
//    -> inst_data_ok with 0xAAAA first, then data_data_ok with 0x5555.
//  5 Full + pop same cycle: count=2, data_req, mem_data_ok=1 -> mem_req=0 that cycle, granted next cycle.
//  6 Spurious: mem_data_ok=1 with empty FIFO -> no data_ok, err_unexpected=1 until resetn=0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared source IDs, memory size codes and the muxed request payload for sram_bus_arbiter.
package sram_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_bus_arbiter_src_id_fifo.sv
// In-order FIFO of 1-bit source IDs for accepted-but-not-returned memory transactions.
module sram_bus_arbiter_src_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  logic i_push_id,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between the IF and EX/MEM requesters with
// fixed priority, grant lock until address acceptance and in-order response routing.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_unexpected
);

    logic     r_lock_vld;
    logic     r_lock_id;
    logic     r_err;

    logic     w_winner;
    logic     w_winner_req;
    logic     w_blocked;
    logic     w_push;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    logic     w_head;
    mem_cmd_t w_inst_cmd;
    mem_cmd_t w_data_cmd;
    mem_cmd_t w_cmd;

    // Locked winner first, then data over inst; with no request the data side drives the fields.
    always_comb begin
        w_winner = SRC_DATA;
        if (r_lock_vld) begin
            w_winner = r_lock_id;
        end else if (data_req) begin
            w_winner = SRC_DATA;
        end else if (inst_req) begin
            w_winner = SRC_INST;
        end
    end

    assign w_winner_req = (w_winner == SRC_INST) ? inst_req : data_req;
    assign w_blocked    = ~resetn | w_full;

    assign w_inst_cmd = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign w_data_cmd = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    assign w_cmd      = (w_winner == SRC_INST) ? w_inst_cmd : w_data_cmd;

    assign mem_req   = w_winner_req & ~w_blocked;
    assign mem_wr    = w_cmd.wr;
    assign mem_size  = w_cmd.size;
    assign mem_wstrb = w_cmd.wstrb;
    assign mem_addr  = w_cmd.addr;
    assign mem_wdata = w_cmd.wdata;

    assign w_push       = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_push & (w_winner == SRC_INST);
    assign data_addr_ok = w_push & (w_winner == SRC_DATA);

    assign w_pop        = resetn & mem_data_ok & ~w_empty;
    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign err_unexpected = r_err;

    // Hold the grant on a stalled requester until the memory takes its address.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
        end else if (mem_req && !mem_addr_ok) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_winner;
        end else if (mem_req && mem_addr_ok) begin
            r_lock_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (mem_data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

    sram_bus_arbiter_src_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_push),
        .i_push_id (w_winner),
        .i_pop     (w_pop),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

endmodule
